exec_cluster: RTL and testbench
===============================

Name: exec_cluster

Overview:
Parametrised execute stage for the Tomasulo core: RS_DEPTH-entry unified reservation station feeding NUM_FU identical pipelined-latency functional units (ADD/SUB/MUL/DIV), sharing one common data bus (CDB) with round-robin arbitration and writeback backpressure. Sits between issue (allocates entries) and writeback/ROB (consumes CDB). Entries capture operands by snooping the block's own CDB.

Parameters:
DATA_W, 16, operand/result width
TAG_W, 4, producer/destination tag width
RS_DEPTH, 4, reservation station entries
NUM_FU, 2, functional units
LATENCY, 3, cycles from dispatch to result valid (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all entries and FUs
alloc_valid  in  1  issue presents an instruction
alloc_ready  out  1  at least one free RS entry
alloc_tag  in  TAG_W  destination tag
alloc_op  in  2  00 SUB, 01 ADD, 10 MUL, 11 DIV
alloc_src1_val / alloc_src2_val  in  DATA_W  operand values
alloc_src1_rdy / alloc_src2_rdy  in  1  operand value valid
alloc_src1_tag / alloc_src2_tag  in  TAG_W  producer tag when not ready
cdb_valid  out  1  result available
cdb_ready  in  1  writeback accepts result
cdb_tag  out  TAG_W  result tag
cdb_data  out  DATA_W  result value
cdb_dz  out  1  divide-by-zero flag
rs_count  out  $clog2(RS_DEPTH+1)  occupied entries
fu_busy  out  NUM_FU  FU not idle

Behaviour:
- Reset: one clock, synchronous active-high on clk. All RS entries invalid, all FUs IDLE, rr_ptr=0; alloc_ready=1, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_dz=0, rs_count=0, fu_busy=0.
- flush: same state effect as rst; priority over alloc, dispatch and CDB handshake in that cycle.
- CDB transfer: cdb_valid && cdb_ready.
- Allocate: alloc_valid && alloc_ready writes lowest-index free entry at clock edge; alloc_valid while !alloc_ready is ignored, no state change.
- Snoop: on a transfer, every valid entry with a non-ready operand whose tag == cdb_tag captures cdb_data and marks the operand ready. Also applies to the operand being allocated in the same cycle (bypass); a same-cycle bypass counts as ready.
- Dispatch, evaluated every cycle on registered state: ready entries (both operands ready) scanned lowest index first; each paired with the lowest-index FU that is IDLE, or DONE and being transferred this cycle. Up to NUM_FU dispatches per cycle. A dispatched entry frees at the same edge. An entry allocated or snooped-ready at edge t dispatches no earlier than edge t+1.
- FU FSM: IDLE -> BUSY on dispatch (counter=LATENCY-1, result computed and registered) -> counts down -> DONE when counter hits 0 (immediately if LATENCY=1). DONE holds tag/data/dz stable until transfer -> IDLE, or -> BUSY if re-dispatched on the same edge.
- Timing: dispatch at end of cycle c -> cdb_valid first possible in cycle c+LATENCY. Alloc in cycle 0 with ready operands -> cdb_valid in cycle 1+LATENCY.
- Arbitration: cdb_valid = any FU DONE. Selected FU is the first DONE at index >= rr_ptr, with wrap. On transfer, rr_ptr <= sel+1 mod NUM_FU. cdb_* outputs are driven combinationally from registered FU state. Outputs are stable while cdb_valid && !cdb_ready.
- Arithmetic, unsigned and truncated to DATA_W: SUB wraps mod 2^DATA_W; MUL keeps low DATA_W bits; DIV is a quotient. For a divisor of 0, the result is all ones and dz=1. dz=0 for every other operation.
- rs_count and alloc_ready reflect registered occupancy; a same-cycle dispatch does not free space for a same-cycle alloc.

Test Plan:
1. ADD, tag 5, 0x0010+0x0003, both ready, cdb_ready=1, defaults -> cdb_valid in cycle 4 only, cdb_tag=5, cdb_data=0x0013, cdb_dz=0.
2. MUL tag 1 (3*4), then ADD tag 2 with src1 waiting on tag 1 and src2=1 -> tag 1 data 0x000C, then tag 2 data 0x000D no earlier than 1+LATENCY cycles after the tag 1 transfer.
3. Fill 4 entries waiting on tag 9 -> alloc_ready=0, rs_count=4; a 5th alloc is dropped; nothing dispatches, fu_busy=0.
4. Both FUs DONE (tags 3, 4), cdb_ready=0 for 3 cycles -> outputs held at tag 3; after cdb_ready=1, tag 3 transfers, then tag 4, rr_ptr ends at 0.
5. DIV 0x1234/0 -> data 0xFFFF, dz=1. SUB 0x0001-0x0002 -> 0xFFFF, dz=0. DIV 0x0009/0x0002 -> 0x0004.
6. flush asserted while 2 FUs are BUSY and 3 entries are valid -> next cycle cdb_valid=0, rs_count=0, fu_busy=0, alloc_ready=1; no stale result ever appears.

Source files
------------

// File: rtl/exec_cluster_if.sv
// Issue/writeback bus of the execute cluster: allocation channel in, common data bus out.
// Handshake: an item moves on a rising clk edge where valid && ready. A raised cdb_valid
// keeps cdb_tag/cdb_data/cdb_dz stable until that edge. alloc_valid without alloc_ready is dropped.
interface exec_cluster_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic [1:0]        alloc_op;
  logic [DATA_W-1:0] alloc_src1_val;
  logic [DATA_W-1:0] alloc_src2_val;
  logic              alloc_src1_rdy;
  logic              alloc_src2_rdy;
  logic [TAG_W-1:0]  alloc_src1_tag;
  logic [TAG_W-1:0]  alloc_src2_tag;
  logic              cdb_valid;
  logic              cdb_ready;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_dz;

  modport master (
    output alloc_valid, alloc_tag, alloc_op, alloc_src1_val, alloc_src2_val,
           alloc_src1_rdy, alloc_src2_rdy, alloc_src1_tag, alloc_src2_tag, cdb_ready,
    input  alloc_ready, cdb_valid, cdb_tag, cdb_data, cdb_dz
  );

  modport slave (
    input  alloc_valid, alloc_tag, alloc_op, alloc_src1_val, alloc_src2_val,
           alloc_src1_rdy, alloc_src2_rdy, alloc_src1_tag, alloc_src2_tag, cdb_ready,
    output alloc_ready, cdb_valid, cdb_tag, cdb_data, cdb_dz
  );
endinterface

// File: rtl/exec_cluster.sv
// Tomasulo execute stage: unified reservation station, NUM_FU fixed-latency units,
// one round-robin arbitrated CDB that the station also snoops for operands.
module exec_cluster #(
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 4,
  parameter int RS_DEPTH = 4,
  parameter int NUM_FU   = 2,
  parameter int LATENCY  = 3,
  localparam int CW      = $clog2(RS_DEPTH + 1),
  localparam int FU_IW   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int RS_IW   = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1,
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  exec_cluster_if.slave       bus,
  output logic [CW-1:0]       rs_count,
  output logic [NUM_FU-1:0]   fu_busy,
  output logic [2*NUM_FU-1:0] fu_state_dbg,
  output logic [FU_IW-1:0]    rr_ptr_dbg
);
  typedef enum logic [1:0] {FU_IDLE = 2'd0, FU_BUSY = 2'd1, FU_DONE = 2'd2} fu_state_t;
  localparam fu_state_t LAUNCH = (LATENCY == 1) ? FU_DONE : FU_BUSY;

  logic [RS_DEPTH-1:0] rs_valid, rs_rdy1, rs_rdy2, disp_en;
  logic [TAG_W-1:0]    rs_tag [RS_DEPTH];
  logic [TAG_W-1:0]    rs_qtag1 [RS_DEPTH];
  logic [TAG_W-1:0]    rs_qtag2 [RS_DEPTH];
  logic [1:0]          rs_op [RS_DEPTH];
  logic [DATA_W-1:0]   rs_val1 [RS_DEPTH];
  logic [DATA_W-1:0]   rs_val2 [RS_DEPTH];

  fu_state_t           fu_state [NUM_FU];
  fu_state_t           fu_state_nxt [NUM_FU];
  logic [CNT_W-1:0]    fu_cnt [NUM_FU];
  logic [TAG_W-1:0]    fu_tag [NUM_FU];
  logic [DATA_W-1:0]   fu_data [NUM_FU];
  logic [NUM_FU-1:0]   fu_dz, fu_go, fu_avail;
  logic [RS_IW-1:0]    fu_src [NUM_FU];

  logic [FU_IW-1:0]    rr_ptr, sel, lock_sel;
  logic                locked, any_done, xfer;
  logic                have_free, alloc_fire, byp1, byp2;
  logic [RS_IW-1:0]    alloc_idx;

  function automatic logic [DATA_W:0] alu(input logic [1:0] op, input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic              dz;
    dz = 1'b0;
    case (op)
      2'b00: r = a - b;
      2'b01: r = a + b;
      2'b10: r = a * b;
      default: begin
        if (b == '0) begin
          r  = '1;
          dz = 1'b1;
        end else begin
          r = a / b;
        end
      end
    endcase
    return {dz, r};
  endfunction

  // Round-robin pick; a stalled winner is pinned so a later DONE cannot steal the bus.
  always_comb begin
    int idx;
    any_done = 1'b0;
    sel      = '0;
    idx      = 0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (fu_state[idx] == FU_DONE) begin
        any_done = 1'b1;
        sel      = FU_IW'(idx);
      end
    end
    if (locked) sel = lock_sel;
  end

  assign xfer          = any_done && bus.cdb_ready;
  assign bus.cdb_valid = any_done;
  assign bus.cdb_tag   = any_done ? fu_tag[sel] : '0;
  assign bus.cdb_data  = any_done ? fu_data[sel] : '0;
  assign bus.cdb_dz    = any_done ? fu_dz[sel] : 1'b0;
  assign rr_ptr_dbg    = rr_ptr;

  always_comb begin
    have_free = 1'b0;
    alloc_idx = '0;
    rs_count  = '0;
    for (int e = RS_DEPTH - 1; e >= 0; e--) begin
      if (!rs_valid[e]) begin
        have_free = 1'b1;
        alloc_idx = RS_IW'(e);
      end
      rs_count = rs_count + CW'(rs_valid[e]);
    end
  end

  assign bus.alloc_ready = have_free;
  assign alloc_fire      = bus.alloc_valid && have_free;
  assign byp1 = !bus.alloc_src1_rdy && xfer && (bus.alloc_src1_tag == bus.cdb_tag);
  assign byp2 = !bus.alloc_src2_rdy && xfer && (bus.alloc_src2_tag == bus.cdb_tag);

  // A DONE unit whose result leaves this cycle is as good as idle for dispatch.
  always_comb begin
    logic placed;
    disp_en = '0;
    fu_go   = '0;
    placed  = 1'b0;
    for (int f = 0; f < NUM_FU; f++) begin
      fu_src[f]   = '0;
      fu_avail[f] = (fu_state[f] == FU_IDLE) ||
                    ((fu_state[f] == FU_DONE) && xfer && (sel == FU_IW'(f)));
    end
    for (int e = 0; e < RS_DEPTH; e++) begin
      placed = 1'b0;
      if (rs_valid[e] && rs_rdy1[e] && rs_rdy2[e]) begin
        for (int f = 0; f < NUM_FU; f++) begin
          if (!placed && fu_avail[f] && !fu_go[f]) begin
            fu_go[f]   = 1'b1;
            fu_src[f]  = RS_IW'(e);
            disp_en[e] = 1'b1;
            placed     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      fu_state_nxt[f] = fu_state[f];
      case (fu_state[f])
        FU_IDLE: if (fu_go[f]) fu_state_nxt[f] = LAUNCH;
        FU_BUSY: if (fu_cnt[f] <= CNT_W'(1)) fu_state_nxt[f] = FU_DONE;
        FU_DONE: begin
          if (fu_go[f]) fu_state_nxt[f] = LAUNCH;
          else if (xfer && (sel == FU_IW'(f))) fu_state_nxt[f] = FU_IDLE;
        end
        default: fu_state_nxt[f] = FU_IDLE;
      endcase
      fu_busy[f]            = (fu_state[f] != FU_IDLE);
      fu_state_dbg[2*f +: 2] = fu_state[f];
    end
  end

  always_ff @(posedge clk) begin
    for (int f = 0; f < NUM_FU; f++) begin
      if (rst || flush) fu_state[f] <= FU_IDLE;
      else              fu_state[f] <= fu_state_nxt[f];
    end
  end

  always_ff @(posedge clk) begin
    for (int f = 0; f < NUM_FU; f++) begin
      if (rst || flush) begin
        fu_cnt[f]  <= '0;
        fu_tag[f]  <= '0;
        fu_data[f] <= '0;
        fu_dz[f]   <= 1'b0;
      end else if (fu_go[f]) begin
        fu_cnt[f]              <= CNT_W'(LATENCY - 1);
        fu_tag[f]              <= rs_tag[fu_src[f]];
        {fu_dz[f], fu_data[f]} <= alu(rs_op[fu_src[f]], rs_val1[fu_src[f]], rs_val2[fu_src[f]]);
      end else if (fu_state[f] == FU_BUSY) begin
        fu_cnt[f] <= fu_cnt[f] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_sel <= '0;
    end else if (xfer) begin
      rr_ptr <= (sel == FU_IW'(NUM_FU - 1)) ? '0 : sel + FU_IW'(1);
      locked <= 1'b0;
    end else if (any_done) begin
      locked   <= 1'b1;
      lock_sel <= sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rs_valid <= '0;
      rs_rdy1  <= '0;
      rs_rdy2  <= '0;
    end else begin
      for (int e = 0; e < RS_DEPTH; e++) begin
        if (disp_en[e]) rs_valid[e] <= 1'b0;
        if (xfer && rs_valid[e]) begin
          if (!rs_rdy1[e] && (rs_qtag1[e] == bus.cdb_tag)) begin
            rs_val1[e] <= bus.cdb_data;
            rs_rdy1[e] <= 1'b1;
          end
          if (!rs_rdy2[e] && (rs_qtag2[e] == bus.cdb_tag)) begin
            rs_val2[e] <= bus.cdb_data;
            rs_rdy2[e] <= 1'b1;
          end
        end
        if (alloc_fire && (alloc_idx == RS_IW'(e))) begin
          rs_valid[e] <= 1'b1;
          rs_tag[e]   <= bus.alloc_tag;
          rs_op[e]    <= bus.alloc_op;
          rs_qtag1[e] <= bus.alloc_src1_tag;
          rs_qtag2[e] <= bus.alloc_src2_tag;
          rs_rdy1[e]  <= bus.alloc_src1_rdy || byp1;
          rs_rdy2[e]  <= bus.alloc_src2_rdy || byp2;
          rs_val1[e]  <= byp1 ? bus.cdb_data : bus.alloc_src1_val;
          rs_val2[e]  <= byp2 ? bus.cdb_data : bus.alloc_src2_val;
        end
      end
    end
  end
endmodule

// File: tb/tb_exec_cluster.sv
// Directed bench for exec_cluster: latency, operand wakeup, full station,
// CDB backpressure with round-robin, arithmetic corner cases and flush.
module tb_exec_cluster;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam int EW     = TAG_W + 1 + DATA_W;
  localparam logic [1:0] OP_SUB = 2'b00, OP_ADD = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic [2:0] rs_count;
  logic [1:0] fu_busy;
  logic [3:0] fu_state_dbg;
  logic [0:0] rr_ptr_dbg;
  int         cyc = 0;
  int         n_run = 0;
  int         n_fail = 0;
  logic [EW-1:0] exp_q[$];

  exec_cluster_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus();

  exec_cluster #(.DATA_W(DATA_W), .TAG_W(TAG_W), .RS_DEPTH(4), .NUM_FU(2), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .rs_count(rs_count),
    .fu_busy(fu_busy), .fu_state_dbg(fu_state_dbg), .rr_ptr_dbg(rr_ptr_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_tag = '0;
    bus.alloc_op = '0;
    bus.alloc_src1_val = '0;
    bus.alloc_src2_val = '0;
    bus.alloc_src1_rdy = 1'b0;
    bus.alloc_src2_rdy = 1'b0;
    bus.alloc_src1_tag = '0;
    bus.alloc_src2_tag = '0;
    bus.cdb_ready = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_alloc(input logic [TAG_W-1:0] tag, input logic [1:0] op,
                          input logic [DATA_W-1:0] v1, input logic r1, input logic [TAG_W-1:0] t1,
                          input logic [DATA_W-1:0] v2, input logic r2, input logic [TAG_W-1:0] t2);
    bus.alloc_valid = 1'b1;
    bus.alloc_tag = tag;
    bus.alloc_op = op;
    bus.alloc_src1_val = v1;
    bus.alloc_src1_rdy = r1;
    bus.alloc_src1_tag = t1;
    bus.alloc_src2_val = v2;
    bus.alloc_src2_rdy = r2;
    bus.alloc_src2_tag = t2;
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic alloc_rr(input logic [TAG_W-1:0] tag, input logic [1:0] op,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    do_alloc(tag, op, a, 1'b1, '0, b, 1'b1, '0);
  endtask

  // scoreboard: compare the next CDB result with the head of exp_q
  task automatic wait_result(input string name, input int budget, output int at_cyc);
    logic [EW-1:0] e;
    int n;
    n = 0;
    at_cyc = -1;
    while (!bus.cdb_valid && n < budget) begin
      step();
      n++;
    end
    if (!bus.cdb_valid) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else if (exp_q.size() == 0) begin
      chk({name, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_tag"},  32'(bus.cdb_tag),  32'(e[EW-1 -: TAG_W]));
      chk({name, "_dz"},   32'(bus.cdb_dz),   32'(e[DATA_W]));
      chk({name, "_data"}, 32'(bus.cdb_data), 32'(e[DATA_W-1:0]));
      at_cyc = cyc;
    end
  endtask

  task automatic run_op(input string name, input logic [TAG_W-1:0] tag, input logic [1:0] op,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [DATA_W-1:0] exp_data, input logic exp_dz);
    int c;
    exp_q.push_back({tag, exp_dz, exp_data});
    alloc_rr(tag, op, a, b);
    wait_result(name, 20, c);
    step();
  endtask

  initial begin
    int c1, c2, seen;

    // reset state
    do_reset();
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rst_cdb_tag", 32'(bus.cdb_tag), 32'd0);
    chk("rst_cdb_data", 32'(bus.cdb_data), 32'd0);
    chk("rst_cdb_dz", 32'(bus.cdb_dz), 32'd0);
    chk("rst_rs_count", 32'(rs_count), 32'd0);
    chk("rst_fu_busy", 32'(fu_busy), 32'd0);
    chk("rst_rr_ptr", 32'(rr_ptr_dbg), 32'd0);

    // 1: ADD latency, result only in cycle 4
    alloc_rr(4'd5, OP_ADD, 16'h0010, 16'h0003);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("t1_idle_c%0d", k), 32'(bus.cdb_valid), 32'd0);
      step();
    end
    chk("t1_valid_c4", 32'(bus.cdb_valid), 32'd1);
    chk("t1_tag", 32'(bus.cdb_tag), 32'd5);
    chk("t1_data", 32'(bus.cdb_data), 32'h0013);
    chk("t1_dz", 32'(bus.cdb_dz), 32'd0);
    step();
    chk("t1_valid_c5", 32'(bus.cdb_valid), 32'd0);

    // 2: dependent ADD wakes from the MUL result on the CDB
    do_reset();
    exp_q.push_back({4'd1, 1'b0, 16'h000C});
    exp_q.push_back({4'd2, 1'b0, 16'h000D});
    alloc_rr(4'd1, OP_MUL, 16'd3, 16'd4);
    do_alloc(4'd2, OP_ADD, 16'h0, 1'b0, 4'd1, 16'd1, 1'b1, 4'd0);
    wait_result("t2_mul", 20, c1);
    step();
    wait_result("t2_add", 20, c2);
    chk("t2_wakeup_lat", 32'(c2 - c1), 32'd4);
    step();

    // 3: station full, fifth alloc dropped, nothing dispatches
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(4'(10 + i), OP_ADD, 16'h0, 1'b0, 4'd9, 16'd1, 1'b1, 4'd0);
    chk("t3_count3", 32'(rs_count), 32'd3);
    chk("t3_ready3", 32'(bus.alloc_ready), 32'd1);
    do_alloc(4'd13, OP_ADD, 16'h0, 1'b0, 4'd9, 16'd1, 1'b1, 4'd0);
    chk("t3_count4", 32'(rs_count), 32'd4);
    chk("t3_ready4", 32'(bus.alloc_ready), 32'd0);
    do_alloc(4'd14, OP_ADD, 16'd1, 1'b1, 4'd0, 16'd1, 1'b1, 4'd0);
    chk("t3_count_drop", 32'(rs_count), 32'd4);
    for (int k = 0; k < 4; k++) step();
    chk("t3_fu_busy", 32'(fu_busy), 32'd0);
    chk("t3_cdb_valid", 32'(bus.cdb_valid), 32'd0);

    // 4: backpressure with both units DONE, round-robin order
    do_reset();
    bus.cdb_ready = 1'b0;
    alloc_rr(4'd3, OP_ADD, 16'd1, 16'd2);
    alloc_rr(4'd4, OP_ADD, 16'd4, 16'd4);
    for (int k = 0; k < 3; k++) step();
    chk("t4_both_done", 32'(fu_state_dbg), 32'b1010);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_hold_valid%0d", k), 32'(bus.cdb_valid), 32'd1);
      chk($sformatf("t4_hold_tag%0d", k), 32'(bus.cdb_tag), 32'd3);
      chk($sformatf("t4_hold_data%0d", k), 32'(bus.cdb_data), 32'd3);
      step();
    end
    bus.cdb_ready = 1'b1;
    chk("t4_first_tag", 32'(bus.cdb_tag), 32'd3);
    step();
    chk("t4_second_valid", 32'(bus.cdb_valid), 32'd1);
    chk("t4_second_tag", 32'(bus.cdb_tag), 32'd4);
    chk("t4_second_data", 32'(bus.cdb_data), 32'd8);
    chk("t4_rr_mid", 32'(rr_ptr_dbg), 32'd1);
    step();
    chk("t4_drained", 32'(bus.cdb_valid), 32'd0);
    chk("t4_rr_end", 32'(rr_ptr_dbg), 32'd0);

    // 5: arithmetic corners
    do_reset();
    run_op("t5_div0", 4'd6, OP_DIV, 16'h1234, 16'h0000, 16'hFFFF, 1'b1);
    run_op("t5_sub_wrap", 4'd7, OP_SUB, 16'h0001, 16'h0002, 16'hFFFF, 1'b0);
    run_op("t5_div", 4'd8, OP_DIV, 16'h0009, 16'h0002, 16'h0004, 1'b0);
    run_op("t5_mul_trunc", 4'd9, OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b0);
    run_op("t5_add_wrap", 4'd10, OP_ADD, 16'hFFFF, 16'h0002, 16'h0001, 1'b0);

    // 6: flush with two busy units and three waiting entries
    do_reset();
    do_alloc(4'd10, OP_ADD, 16'h0, 1'b0, 4'd9, 16'd1, 1'b1, 4'd0);
    do_alloc(4'd11, OP_ADD, 16'h0, 1'b0, 4'd9, 16'd1, 1'b1, 4'd0);
    alloc_rr(4'd12, OP_ADD, 16'd1, 16'd1);
    alloc_rr(4'd13, OP_ADD, 16'd2, 16'd2);
    do_alloc(4'd14, OP_ADD, 16'h0, 1'b0, 4'd9, 16'd1, 1'b1, 4'd0);
    chk("t6_pre_busy", 32'(fu_state_dbg), 32'b0101);
    chk("t6_pre_count", 32'(rs_count), 32'd3);
    flush = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_src1_rdy = 1'b1;
    bus.alloc_src2_rdy = 1'b1;
    step();
    flush = 1'b0;
    bus.alloc_valid = 1'b0;
    chk("t6_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("t6_rs_count", 32'(rs_count), 32'd0);
    chk("t6_fu_busy", 32'(fu_busy), 32'd0);
    chk("t6_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.cdb_valid) seen++;
      step();
    end
    chk("t6_no_stale", 32'(seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
